// File: rtl/cmd_exec_inject.sv
// Download write buffer draining into CPU RAM, plus an execute launcher that
// holds the CPU in reset and then injects a JP <addr> opcode sequence.
module cmd_exec_inject #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned RST_CYCLES = 16
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        dl_busy,
    input  logic        dl_wr,
    input  logic [15:0] dl_addr,
    input  logic [7:0]  dl_data,
    input  logic        exec_en,
    input  logic [15:0] exec_addr,
    input  logic        ram_free,
    input  logic        cpu_rd_start,
    output logic        dl_wait,
    output logic        ram_we,
    output logic [15:0] ram_addr,
    output logic [7:0]  ram_din,
    output logic        cpu_reset_req,
    output logic        inj_sel,
    output logic [7:0]  inj_data,
    output logic        overflow
);

    localparam int unsigned PW  = $clog2(FIFO_DEPTH);
    localparam int unsigned CW  = PW + 1;
    localparam int unsigned RCW = $clog2(RST_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRAIN,
        S_RST,
        S_INJ0,
        S_INJ1,
        S_INJ2
    } state_t;

    logic [15:0]   addr_mem [FIFO_DEPTH];
    logic [7:0]    data_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          dl_wait_q, ram_we_q, overflow_q;
    logic [15:0]   ram_addr_q;
    logic [7:0]    ram_din_q;
    logic          push_c, pop_c, drop_c, full_c;

    state_t         state_q, state_d;
    logic [RCW-1:0] cnt_q, cnt_d;
    logic           exec_pend_q, exec_pend_d;
    logic [15:0]    exec_addr_q, exec_addr_d;
    logic           shd_pend_q, shd_pend_d;
    logic [15:0]    shd_addr_q, shd_addr_d;
    logic           launch_c;
    logic           cpu_reset_req_q, inj_sel_q;
    logic [7:0]     inj_data_q, inj_data_d;

    // A full buffer still accepts a write when an entry leaves in the same cycle.
    always_comb begin
        full_c  = (count_q == CW'(FIFO_DEPTH));
        pop_c   = (count_q != '0) && ram_free;
        push_c  = dl_wr && (!full_c || pop_c);
        drop_c  = dl_wr && full_c && !pop_c;
        count_d = count_q + CW'(push_c) - CW'(pop_c);
    end

    always_ff @(posedge clk_sys) begin
        if (push_c) begin
            addr_mem[wr_ptr_q] <= dl_addr;
            data_mem[wr_ptr_q] <= dl_data;
        end
    end

    always_ff @(posedge clk_sys or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            dl_wait_q  <= 1'b0;
            ram_we_q   <= 1'b0;
            ram_addr_q <= '0;
            ram_din_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            dl_wait_q  <= (count_d >= CW'(FIFO_DEPTH - 1));
            ram_we_q   <= pop_c;
            overflow_q <= overflow_q | drop_c;
            if (push_c) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop_c) begin
                rd_ptr_q   <= rd_ptr_q + PW'(1);
                ram_addr_q <= addr_mem[rd_ptr_q];
                ram_din_q  <= data_mem[rd_ptr_q];
            end
        end
    end

    // Launch sequencer next state.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        launch_c = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (exec_pend_q) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!dl_busy && (count_q == '0)) begin
                    state_d  = S_RST;
                    cnt_d    = RCW'(RST_CYCLES - 1);
                    launch_c = 1'b1;
                end
            end
            S_RST: begin
                if (cnt_q == '0) begin
                    state_d = S_INJ0;
                end else begin
                    cnt_d = cnt_q - RCW'(1);
                end
            end
            S_INJ0: if (cpu_rd_start) state_d = S_INJ1;
            S_INJ1: if (cpu_rd_start) state_d = S_INJ2;
            S_INJ2: if (cpu_rd_start) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Requests before launch overwrite the live address; later ones wait in the shadow.
    always_comb begin
        exec_pend_d = exec_pend_q;
        exec_addr_d = exec_addr_q;
        shd_pend_d  = shd_pend_q;
        shd_addr_d  = shd_addr_q;
        if ((state_q == S_IDLE) && shd_pend_q) begin
            exec_pend_d = 1'b1;
            exec_addr_d = shd_addr_q;
            shd_pend_d  = 1'b0;
        end
        if (exec_en) begin
            if ((state_q == S_IDLE) || (state_q == S_DRAIN)) begin
                exec_pend_d = 1'b1;
                exec_addr_d = exec_addr;
            end else begin
                shd_pend_d = 1'b1;
                shd_addr_d = exec_addr;
            end
        end
        if (launch_c) begin
            exec_pend_d = 1'b0;
        end
    end

    always_comb begin
        inj_data_d = 8'h00;
        case (state_d)
            S_INJ0:  inj_data_d = 8'hC3;
            S_INJ1:  inj_data_d = exec_addr_q[7:0];
            S_INJ2:  inj_data_d = exec_addr_q[15:8];
            default: inj_data_d = 8'h00;
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset) begin
        if (!reset) begin
            state_q         <= S_IDLE;
            cnt_q           <= '0;
            exec_pend_q     <= 1'b0;
            exec_addr_q     <= '0;
            shd_pend_q      <= 1'b0;
            shd_addr_q      <= '0;
            cpu_reset_req_q <= 1'b0;
            inj_sel_q       <= 1'b0;
            inj_data_q      <= 8'h00;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            exec_pend_q     <= exec_pend_d;
            exec_addr_q     <= exec_addr_d;
            shd_pend_q      <= shd_pend_d;
            shd_addr_q      <= shd_addr_d;
            cpu_reset_req_q <= (state_d == S_RST);
            inj_sel_q       <= (state_d == S_INJ0) || (state_d == S_INJ1) || (state_d == S_INJ2);
            inj_data_q      <= inj_data_d;
        end
    end

    assign dl_wait       = dl_wait_q;
    assign ram_we        = ram_we_q;
    assign ram_addr      = ram_addr_q;
    assign ram_din       = ram_din_q;
    assign overflow      = overflow_q;
    assign cpu_reset_req = cpu_reset_req_q;
    assign inj_sel       = inj_sel_q;
    assign inj_data      = inj_data_q;

endmodule

// File: tb/tb_cmd_exec_inject.sv
// Bench for cmd_exec_inject: queue model of the write buffer checked every
// cycle, directed launch/injection sequences and randomized traffic.
module tb_cmd_exec_inject;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned RSTC  = 16;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        dl_busy, dl_wr, exec_en, ram_free, cpu_rd_start;
    logic [15:0] dl_addr, exec_addr;
    logic [7:0]  dl_data;
    logic        dl_wait, ram_we, cpu_reset_req, inj_sel, overflow;
    logic [15:0] ram_addr;
    logic [7:0]  ram_din, inj_data;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [15:0] a;
        logic [7:0]  d;
    } ent_t;

    ent_t mq[$];
    ent_t seen[$];
    bit   m_ovf;

    cmd_exec_inject #(.FIFO_DEPTH(DEPTH), .RST_CYCLES(RSTC)) dut (
        .clk_sys(clk_sys), .reset(reset), .dl_busy(dl_busy), .dl_wr(dl_wr),
        .dl_addr(dl_addr), .dl_data(dl_data), .exec_en(exec_en), .exec_addr(exec_addr),
        .ram_free(ram_free), .cpu_rd_start(cpu_rd_start), .dl_wait(dl_wait),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
        .cpu_reset_req(cpu_reset_req), .inj_sel(inj_sel), .inj_data(inj_data),
        .overflow(overflow)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: advance the buffer model with the applied inputs, then compare.
    task automatic step();
        bit   pop;
        bit   push;
        ent_t p;
        ent_t n;
        p   = '0;
        pop = (mq.size() > 0) && (ram_free === 1'b1);
        if (pop) p = mq.pop_front();
        push = (dl_wr === 1'b1) && (mq.size() < DEPTH);
        if ((dl_wr === 1'b1) && !push) m_ovf = 1'b1;
        if (push) begin
            n.a = dl_addr;
            n.d = dl_data;
            mq.push_back(n);
        end
        @(posedge clk_sys);
        #1;
        check("ram_we", 32'(ram_we), 32'(pop));
        if (pop) begin
            check("ram_addr", 32'(ram_addr), 32'(p.a));
            check("ram_din", 32'(ram_din), 32'(p.d));
        end
        if (ram_we === 1'b1) begin
            n.a = ram_addr;
            n.d = ram_din;
            seen.push_back(n);
        end
        check("dl_wait", 32'(dl_wait), 32'(mq.size() >= DEPTH - 1));
        check("overflow", 32'(overflow), 32'(m_ovf));
    endtask

    task automatic zero_inputs();
        dl_busy = 0; dl_wr = 0; exec_en = 0; ram_free = 0; cpu_rd_start = 0;
        dl_addr = '0; dl_data = '0; exec_addr = '0;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        zero_inputs();
        #2;
        check("rst_ram_we", 32'(ram_we), 32'd0);
        check("rst_ram_addr", 32'(ram_addr), 32'd0);
        check("rst_ram_din", 32'(ram_din), 32'd0);
        check("rst_dl_wait", 32'(dl_wait), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_cpu_reset_req", 32'(cpu_reset_req), 32'd0);
        check("rst_inj_sel", 32'(inj_sel), 32'd0);
        check("rst_inj_data", 32'(inj_data), 32'd0);
        @(posedge clk_sys);
        #1;
        reset = 1'b1;
        mq.delete();
        seen.delete();
        m_ovf = 1'b0;
    endtask

    task automatic write(input logic [15:0] a, input logic [7:0] d);
        dl_wr = 1; dl_addr = a; dl_data = d;
        step();
        dl_wr = 0;
    endtask

    task automatic request(input logic [15:0] a);
        exec_en = 1; exec_addr = a;
        step();
        exec_en = 0;
    endtask

    task automatic rd_pulse();
        cpu_rd_start = 1;
        step();
        cpu_rd_start = 0;
    endtask

    task automatic expect_inj(input string tag, input logic sel, input logic [7:0] d);
        check({tag, "_sel"}, 32'(inj_sel), 32'(sel));
        check({tag, "_data"}, 32'(inj_data), 32'(d));
    endtask

    // Waits for launch, then checks the reset pulse length and lands in the first injection.
    task automatic expect_launch(input string tag);
        int n;
        n = 0;
        while (cpu_reset_req !== 1'b1 && n < 200) begin
            n++;
            step();
        end
        check({tag, "_launch_seen"}, 32'(cpu_reset_req), 32'd1);
        check({tag, "_fifo_empty_at_launch"}, 32'(mq.size()), 32'd0);
        n = 0;
        while (cpu_reset_req === 1'b1 && n < 100) begin
            n++;
            step();
        end
        check({tag, "_reset_cycles"}, 32'(n), 32'(RSTC));
        expect_inj({tag, "_inj0"}, 1'b1, 8'hC3);
    endtask

    task automatic full_injection(input string tag, input logic [15:0] a);
        expect_launch(tag);
        rd_pulse();
        expect_inj({tag, "_inj1"}, 1'b1, a[7:0]);
        rd_pulse();
        expect_inj({tag, "_inj2"}, 1'b1, a[15:8]);
        rd_pulse();
        expect_inj({tag, "_done"}, 1'b0, 8'h00);
    endtask

    initial begin
        logic [15:0] ra;
        zero_inputs();
        reset = 1'b1;
        m_ovf = 1'b0;
        #1;
        apply_reset();

        // Two writes with a free RAM port drain in order, no throttle.
        ram_free = 1;
        write(16'h5200, 8'hAA);
        write(16'h5201, 8'hBB);
        repeat (4) step();
        check("basic_write_count", 32'(seen.size()), 32'd2);
        if (seen.size() == 2) begin
            check("basic_first", 32'(seen[0]), 32'h5200AA);
            check("basic_second", 32'(seen[1]), 32'h5201BB);
        end

        // Blocked RAM: throttle after the third push, fifth write overflows.
        apply_reset();
        ram_free = 0;
        write(16'h1000, 8'h01);
        write(16'h1001, 8'h02);
        check("wait_after_2", 32'(dl_wait), 32'd0);
        write(16'h1002, 8'h03);
        check("wait_after_3", 32'(dl_wait), 32'd1);
        write(16'h1003, 8'h04);
        check("ovf_before_5", 32'(overflow), 32'd0);
        write(16'h1004, 8'h05);
        check("ovf_after_5", 32'(overflow), 32'd1);
        ram_free = 1;
        repeat (8) step();
        check("ovf_drain_count", 32'(seen.size()), 32'd4);
        if (seen.size() == 4) begin
            check("ovf_drain_0", 32'(seen[0]), 32'h100001);
            check("ovf_drain_3", 32'(seen[3]), 32'h100304);
        end
        check("ovf_sticky", 32'(overflow), 32'd1);

        // Randomized buffer traffic against the queue model.
        apply_reset();
        for (int i = 0; i < 600; i++) begin
            dl_wr    = ($urandom_range(0, 99) < 55);
            dl_addr  = 16'($urandom);
            dl_data  = 8'($urandom);
            ram_free = ($urandom_range(0, 99) < ((i < 300) ? 75 : 35));
            step();
        end
        dl_wr = 0;
        ram_free = 1;
        repeat (8) step();

        // Launch waits for the download to finish and the buffer to empty.
        apply_reset();
        dl_busy = 1;
        write(16'h2000, 8'h11);
        write(16'h2001, 8'h22);
        request(16'h5A00);
        for (int i = 0; i < 10; i++) begin
            step();
            check("busy_hold", 32'(cpu_reset_req), 32'd0);
        end
        dl_busy = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("nonempty_hold", 32'(cpu_reset_req), 32'd0);
        end
        ram_free = 1;
        full_injection("jp5a00", 16'h5A00);
        rd_pulse();
        expect_inj("extra_pulse", 1'b0, 8'h00);
        repeat (20) step();
        check("no_relaunch", 32'(cpu_reset_req), 32'd0);
        check("no_reinject", 32'(inj_sel), 32'd0);

        // Last request before launch wins; request during injection queues.
        dl_busy = 1;
        request(16'h6000);
        request(16'h7000);
        step();
        dl_busy = 0;
        expect_launch("jp7000");
        rd_pulse();
        expect_inj("jp7000_inj1", 1'b1, 8'h00);
        request(16'h8000);
        expect_inj("jp7000_hold", 1'b1, 8'h00);
        rd_pulse();
        expect_inj("jp7000_inj2", 1'b1, 8'h70);
        rd_pulse();
        expect_inj("jp7000_done", 1'b0, 8'h00);
        full_injection("jp8000", 16'h8000);

        // Random entry addresses.
        for (int k = 0; k < 3; k++) begin
            ra = 16'($urandom);
            request(ra);
            full_injection("jprand", ra);
        end

        // Reset in the middle of an injection with buffered writes.
        ram_free = 0;
        request(16'h1234);
        expect_launch("jp1234");
        rd_pulse();
        write(16'h3000, 8'h33);
        write(16'h3001, 8'h44);
        apply_reset();
        ram_free = 1;
        for (int i = 0; i < 30; i++) begin
            step();
            check("post_rst_inj_sel", 32'(inj_sel), 32'd0);
            check("post_rst_cpu_reset", 32'(cpu_reset_req), 32'd0);
        end
        check("post_rst_no_writes", 32'(seen.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cmd_exec_inject.md
CMD_EXEC_INJECT -- requirements
Module: cmd_exec_inject

Interface
REQ-001 FIFO_DEPTH, 4, download write buffer entries (power of two, >=2).
REQ-002 RST_CYCLES, 16, clk_sys cycles cpu_reset_req is held during launch.
REQ-003 clk_sys  in  1  system clock; all logic on rising edge.
REQ-004 reset  in  1  asynchronous, active-low.
REQ-005 dl_busy  in  1  CMD download in progress (loader_download).
REQ-006 dl_wr  in  1  one-cycle write strobe from loader.
REQ-007 dl_addr  in  16  loader write address.
REQ-008 dl_data  in  8  loader write data.
REQ-009 exec_en  in  1  one-cycle execute request.
REQ-010 exec_addr  in  16  program entry address, valid with exec_en.
REQ-011 ram_free  in  1  CPU not using RAM port this cycle.
REQ-012 cpu_rd_start  in  1  one-cycle pulse at start of each CPU memory read.
REQ-013 dl_wait  out  1  throttle to loader (ioctl_wait).
REQ-014 ram_we  out  1  RAM write strobe, one cycle per drained entry.
REQ-015 ram_addr  out  16  RAM write address.
REQ-016 ram_din  out  8  RAM write data.
REQ-017 cpu_reset_req  out  1  hold CPU in reset.
REQ-018 inj_sel  out  1  CPU data bus takes inj_data instead of RAM.
REQ-019 inj_data  out  8  injected opcode/operand byte.
REQ-020 overflow  out  1  sticky: write arrived while FIFO full.

Function
REQ-021 FIFO push on dl_wr when not full; pop when non-empty and ram_free; push and pop in same cycle SHALL both occur, count unchanged.
REQ-022 Popped entry SHALL appear on ram_addr/ram_din with ram_we high in the same cycle as pop; ram_we low otherwise.
REQ-023 dl_wait SHALL be high when count >= FIFO_DEPTH-1 (registered, one entry slack).
REQ-024 dl_wr while full (count == FIFO_DEPTH, no pop) SHALL be dropped and set overflow; overflow clears only on reset.
REQ-025 Read/write pointers SHALL wrap modulo FIFO_DEPTH; count width log2(FIFO_DEPTH)+1.
REQ-026 exec_en SHALL latch exec_addr and set exec_pend; later exec_en before launch overwrites address (last wins).
REQ-027 FSM states: IDLE, DRAIN, RST, INJ0, INJ1, INJ2.
REQ-028 IDLE -> DRAIN when exec_pend.
REQ-029 DRAIN -> RST when dl_busy low and FIFO empty; exec_pend cleared, counter loaded RST_CYCLES-1.
REQ-030 RST: cpu_reset_req high, counter decrements; at 0 -> INJ0, cpu_reset_req low next cycle.
REQ-031 INJ0/1/2: inj_sel high; inj_data = 0xC3, exec_addr[7:0], exec_addr[15:8] respectively; advance on cpu_rd_start; INJ2 + cpu_rd_start -> IDLE, inj_sel low next cycle.
REQ-032 exec_en during RST/INJx SHALL set exec_pend and update the latched address only after return to IDLE (queued in shadow register); injection in progress uses unchanged address.
REQ-033 FIFO SHALL continue accepting and draining in all FSM states.
REQ-034 inj_data SHALL be 0x00 when inj_sel low.

Reset
REQ-035 On reset low: FIFO empty, pointers 0, dl_wait 0, ram_we 0, ram_addr 0, ram_din 0, overflow 0, exec_pend 0, FSM IDLE, cpu_reset_req 0, inj_sel 0, inj_data 0x00.
REQ-036 Reset mid-drain or mid-injection SHALL discard FIFO contents and pending execute; no further ram_we or inj_sel until new stimulus.

Verification
REQ-037 ram_free=1, dl_wr writes 0x5200<-0xAA, 0x5201<-0xBB -> ram_we one cycle each, same order, addresses/data exact, dl_wait never high.
REQ-038 ram_free=0, 4 back-to-back dl_wr -> dl_wait high after 3rd push; 5th write sets overflow=1, dropped; ram_free=1 drains exactly 4 entries in order.
REQ-039 dl_busy=1, exec_en with exec_addr=0x5A00, 2 entries queued -> no cpu_reset_req until dl_busy low and FIFO empty; then cpu_reset_req high exactly 16 cycles.
REQ-040 After launch, 3 cpu_rd_start pulses -> inj_data 0xC3, 0x00, 0x5A with inj_sel high; inj_sel low after 3rd; 4th pulse no effect.
REQ-041 exec_en 0x6000 then 0x7000 before launch -> injected address 0x7000; exec_en 0x8000 during INJ1 -> current injection completes, then second launch with 0x8000.
REQ-042 Assert reset during INJ1 with 2 FIFO entries -> all outputs at reset values, no ram_we and no inj_sel after release.
